bec_codec_arbiter: RTL and testbench
====================================

BEC_CODEC_ARBITER -- requirements
Module: bec_codec_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, width of the saturating event counters.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a_valid  input  1  requester A has an operation pending.
REQ-005 a_ready  output  1  requester A operation accepted this cycle when a_valid also high.
REQ-006 a_op  input  1  requester A operation: 0 = encode, 1 = decode.
REQ-007 a_data  input  44  requester A operand: encode uses bits [43:12] as 32-bit message (MSB = message bit 0), ignores [11:0]; decode uses full 44-bit codeword, {message, parity}.
REQ-008 b_valid, b_ready, b_op, b_data  same directions, widths and meaning as the A signals, for requester B.
REQ-009 rsp_valid  output  1  result register holds a valid result.
REQ-010 rsp_ready  input  1  consumer takes the result this cycle when rsp_valid also high.
REQ-011 rsp_src  output  1  requester owning the result: 0 = A, 1 = B.
REQ-012 rsp_data  output  44  encode: full 44-bit (44,32) burst-correcting codeword; decode: corrected 32-bit message in [43:12], zeros in [11:0].
REQ-013 rsp_corr  output  1  decode only: corrected message differs from received message bits.
REQ-014 rsp_resid  output  1  decode only: re-encoded parity of corrected message differs from received parity bits (parity-field burst, or uncorrectable pattern).
REQ-015 cnt_clr  input  1  synchronous clear of both counters.
REQ-016 corr_cnt  output  CNT_W  number of accepted decodes with rsp_corr set.
REQ-017 resid_cnt  output  CNT_W  number of accepted decodes with rsp_resid set.

Function
REQ-018 Block shall contain one shared (44,32) burst-5 encoder and one shared decoder with the team's standard parity and syndrome equations, both purely combinational on the selected operand.
REQ-019 Output buffer FSM shall have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-020 Block may accept a request ("slot free") when the FSM is in EMPTY, or when it is in FULL with rsp_ready=1.
REQ-021 When the slot is free and exactly one requester is valid, that requester shall be granted; when both are valid, the requester selected by the round-robin pointer rr shall be granted.
REQ-022 rr shall point to the requester not granted, updated only on an accepted request; after reset rr shall favour A.
REQ-023 a_ready and b_ready shall be combinational: high only for the granted requester while the slot is free; at most one is high in any cycle.
REQ-024 Latency: a request accepted at edge N shall appear on rsp_* from edge N onward, i.e. in the cycle after acceptance, with rsp_valid=1.
REQ-025 A result shall remain stable while rsp_valid=1 and rsp_ready=0.
REQ-026 In FULL, rsp_ready=1 with a grant shall load the new result back-to-back (FSM stays FULL); rsp_ready=1 with no grant shall move the FSM to EMPTY.
REQ-027 Encode results shall force rsp_corr=0 and rsp_resid=0.
REQ-028 Counters shall increment by one at acceptance of a decode whose corr/resid flag is computed as 1, and saturate at 2^CNT_W-1 without wrapping.
REQ-029 cnt_clr shall have priority over a same-cycle increment; counters shall read 0 in the following cycle.
REQ-030 Requesters may drop valid or change op/data before a grant; the block shall sample operands only at acceptance.

Reset
REQ-031 While rst=1: FSM=EMPTY, rsp_valid=0, rsp_src=0, rsp_data=0, rsp_corr=0, rsp_resid=0, rr=A, corr_cnt=0, resid_cnt=0, and a_ready=b_ready=0.
REQ-032 Reset asserted mid-transaction shall discard the held result; no counter update or grant shall survive it.
REQ-033 First acceptance shall be possible on the first rising edge after rst deasserts.

Verification
REQ-034 A encode of 0x00000001 (a_data=0x00000001000) -> next cycle rsp_valid=1, rsp_src=0, rsp_data=0x00000001081, rsp_corr=0, rsp_resid=0.
REQ-035 B decode of 0x00000000081 (message bit 31 flipped) -> rsp_data[43:12]=0x00000001, rsp_corr=1, rsp_resid=0, corr_cnt=1.
REQ-036 A decode of 0x00000001881 (parity bit 0 flipped) -> rsp_data[43:12]=0x00000001, rsp_corr=0, rsp_resid=1, resid_cnt=1.
REQ-037 A and B valid continuously with rsp_ready=1 -> grants alternate A,B,A,B; one result per cycle; rsp_src alternates.
REQ-038 rsp_ready=0 for 3 cycles with both valid -> rsp_* held, a_ready=b_ready=0; when rsp_ready rises, the next grant goes to the rr requester.
REQ-039 corr_cnt preloaded to 0xFFFF by corrected decodes -> further corrected decodes keep it at 0xFFFF; cnt_clr with a simultaneous corrected decode -> 0; rst mid-FULL -> rsp_valid=0 immediately.

Source files
------------

// File: rtl/bec_codec_arbiter.sv
// Two-requester arbiter in front of a shared (44,32) burst-5 encoder/decoder
// (generator x^12 + x^7 + 1) with a one-entry result buffer and saturating event counters.
module bec_codec_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             a_op,
  input  logic [43:0]      a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             b_op,
  input  logic [43:0]      b_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_src,
  output logic [43:0]      rsp_data,
  output logic             rsp_corr,
  output logic             rsp_resid,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] resid_cnt
);

  localparam logic [11:0] GEN = 12'h081;

  // Remainder of msg(x)*x^12 mod g(x); msg[31] is the highest-degree term (codeword bit 43).
  function automatic logic [11:0] enc_parity(input logic [31:0] msg);
    logic [11:0] rem;
    logic        fb;
    rem = '0;
    for (int j = 31; j >= 0; j--) begin
      fb  = msg[j] ^ rem[11];
      rem = {rem[10:0], 1'b0} ^ (fb ? GEN : 12'h000);
    end
    return rem;
  endfunction

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_reg, state_next;
  logic             rr_reg;
  logic             slot_free, grant_a, grant_b, accept;
  logic             op_sel;
  logic [43:0]      data_sel;
  logic [11:0]      par_sel, syn;
  logic [11:0]      s_chain [0:43];
  logic [43:0]      err_vec [0:43];
  logic [43:0]      match;
  logic [43:0]      err, corrected;
  logic             dec_corr, dec_resid;
  logic [43:0]      res_data;
  logic             res_corr, res_resid;
  logic             rsp_src_reg, rsp_corr_reg, rsp_resid_reg;
  logic [43:0]      rsp_data_reg;
  logic [CNT_W-1:0] corr_cnt_reg, resid_cnt_reg;

  // Operand selection and shared encoder.
  assign op_sel   = grant_b ? b_op : a_op;
  assign data_sel = grant_b ? b_data : a_data;
  assign par_sel  = enc_parity(data_sel[43:12]);
  assign syn      = par_sel ^ data_sel[11:0];

  // s_chain[p] = syndrome * x^-p mod g; a burst starting at bit p leaves it confined to bits [4:0].
  assign s_chain[0] = syn;
  for (genvar gi = 1; gi < 44; gi++) begin : g_chain
    assign s_chain[gi] = {s_chain[gi-1][0],
                          s_chain[gi-1][11:1] ^ (s_chain[gi-1][0] ? GEN[11:1] : 11'h000)};
  end

  for (genvar gi = 0; gi < 44; gi++) begin : g_trap
    logic [48:0] burst_wide;
    assign burst_wide  = 49'(s_chain[gi][4:0]) << gi;
    assign err_vec[gi] = burst_wide[43:0];
    assign match[gi]   = s_chain[gi][0] && (s_chain[gi][11:5] == 7'd0) && (burst_wide[48:44] == 5'd0);
  end

  // Lowest start position wins when several bursts explain the syndrome.
  always_comb begin
    err = '0;
    for (int p = 43; p >= 0; p--) begin
      if (match[p]) err = err_vec[p];
    end
  end

  assign corrected = data_sel ^ err;
  assign dec_corr  = |err[43:12];
  assign dec_resid = enc_parity(corrected[43:12]) != data_sel[11:0];

  assign res_data  = op_sel ? {corrected[43:12], 12'h000} : {data_sel[43:12], par_sel};
  assign res_corr  = op_sel && dec_corr;
  assign res_resid = op_sel && dec_resid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  always_comb begin
    slot_free  = (state_reg == EMPTY) || rsp_ready;
    grant_a    = slot_free && a_valid && (!b_valid || !rr_reg);
    grant_b    = slot_free && b_valid && (!a_valid || rr_reg);
    accept     = grant_a || grant_b;
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (rsp_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  assign a_ready = grant_a && !rst;
  assign b_ready = grant_b && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_reg        <= 1'b0;
      rsp_src_reg   <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_corr_reg  <= 1'b0;
      rsp_resid_reg <= 1'b0;
    end else if (accept) begin
      rr_reg        <= grant_a;
      rsp_src_reg   <= grant_b;
      rsp_data_reg  <= res_data;
      rsp_corr_reg  <= res_corr;
      rsp_resid_reg <= res_resid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt_reg  <= '0;
      resid_cnt_reg <= '0;
    end else if (cnt_clr) begin
      corr_cnt_reg  <= '0;
      resid_cnt_reg <= '0;
    end else begin
      if (accept && res_corr && (corr_cnt_reg != '1))
        corr_cnt_reg <= corr_cnt_reg + CNT_W'(1);
      if (accept && res_resid && (resid_cnt_reg != '1))
        resid_cnt_reg <= resid_cnt_reg + CNT_W'(1);
    end
  end

  assign rsp_valid = (state_reg == FULL);
  assign rsp_src   = rsp_src_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_corr  = rsp_corr_reg;
  assign rsp_resid = rsp_resid_reg;
  assign corr_cnt  = corr_cnt_reg;
  assign resid_cnt = resid_cnt_reg;

endmodule

// File: tb/tb_bec_codec_arbiter.sv
// Scoreboard bench for bec_codec_arbiter: stimulus pushes hand-computed results, a monitor pops on each consumed response.
module tb_bec_codec_arbiter;

  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, a_ready, a_op;
  logic [43:0]      a_data;
  logic             b_valid, b_ready, b_op;
  logic [43:0]      b_data;
  logic             rsp_valid, rsp_ready, rsp_src, rsp_corr, rsp_resid;
  logic [43:0]      rsp_data;
  logic             cnt_clr;
  logic [CNT_W-1:0] corr_cnt, resid_cnt;

  always #5 clk = ~clk;

  bec_codec_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_data(b_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
    .rsp_data(rsp_data), .rsp_corr(rsp_corr), .rsp_resid(rsp_resid),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .resid_cnt(resid_cnt)
  );

  typedef struct packed {
    logic        src;
    logic [43:0] data;
    logic        corr;
    logic        resid;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   corr_exp = 0;
  int   resid_exp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: one comparison set per consumed response.
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: got data %h expected none", rsp_data);
        end else begin
          e = sb.pop_front();
          check("rsp_src",   64'(rsp_src),   64'(e.src));
          check("rsp_data",  64'(rsp_data),  64'(e.data));
          check("rsp_corr",  64'(rsp_corr),  64'(e.corr));
          check("rsp_resid", 64'(rsp_resid), 64'(e.resid));
          $display("rsp src=%0d data=%h corr=%0d resid=%0d", rsp_src, rsp_data, rsp_corr, rsp_resid);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic issue(input logic src, input logic op, input logic [43:0] data,
                       input logic [43:0] exp_data, input logic ec, input logic er);
    int k;
    sb.push_back({src, exp_data, ec, er});
    if (src) begin b_valid = 1'b1; b_op = op; b_data = data; end
    else     begin a_valid = 1'b1; a_op = op; a_data = data; end
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (src ? b_ready : a_ready) break;
    end
    if (k == 20) begin
      n_vec++;
      n_err++;
      $display("FAIL grant_timeout: got no ready expected ready for src %0d", src);
    end
    @(posedge clk);
    #1;
    if (src) b_valid = 1'b0; else a_valid = 1'b0;
    if (ec && corr_exp < MAXC)  corr_exp++;
    if (er && resid_exp < MAXC) resid_exp++;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts();
    @(negedge clk);
    check("corr_cnt",  64'(corr_cnt),  64'(corr_exp));
    check("resid_cnt", 64'(resid_cnt), 64'(resid_exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    corr_exp  = 0;
    resid_exp = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cnt_clr = 1'b0; rsp_ready = 1'b1;
    a_valid = 1'b1; a_op = 1'b0; a_data = 44'h00000001000;
    b_valid = 1'b0; b_op = 1'b0; b_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(rsp_data),  64'd0);
    check("rst_rsp_src",   64'(rsp_src),   64'd0);
    check("rst_flags",     64'({rsp_corr, rsp_resid}), 64'd0);
    check("rst_cnts",      64'({corr_cnt, resid_cnt}), 64'd0);
    check("rst_a_ready",   64'(a_ready),   64'd0);

    // First acceptance on the first edge after reset release.
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.push_back({1'b0, 44'h00000001081, 1'b0, 1'b0});
    @(negedge clk);
    check("first_a_ready", 64'(a_ready), 64'd1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;

    issue(1, 1, 44'h00000000081, 44'h00000001000, 1, 0);  // message bit 31 flipped
    issue(0, 1, 44'h00000001881, 44'h00000001000, 0, 1);  // parity bit 0 flipped
    issue(0, 0, 44'h00000002000, 44'h00000002102, 0, 0);
    issue(1, 0, 44'h00000020000, 44'h000000200A1, 0, 0);
    issue(0, 1, 44'h00000000183, 44'h00000003000, 1, 0);  // 2-bit burst in message
    issue(1, 1, 44'h00000000881, 44'h00000001000, 1, 1);  // burst across parity/message boundary
    issue(0, 1, 44'h00000002102, 44'h00000002000, 0, 0);  // clean codeword
    issue(1, 0, 44'h00000004FFF, 44'h00000004204, 0, 0);  // low operand bits ignored on encode
    drain();
    check_cnts();

    for (int i = 0; i < 14; i++) issue(1, 1, 44'h00000000081, 44'h00000001000, 1, 0);
    drain();
    check_cnts();

    cnt_clr = 1'b1;
    issue(1, 1, 44'h00000000081, 44'h00000001000, 1, 0);
    cnt_clr   = 1'b0;
    corr_exp  = 0;
    resid_exp = 0;
    drain();
    check_cnts();

    // Round-robin alternation under continuous demand.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sb.push_back({1'b0, 44'h00000001081, 1'b0, 1'b0});
      sb.push_back({1'b1, 44'h00000002102, 1'b0, 1'b0});
    end
    a_valid = 1'b1; a_op = 1'b0; a_data = 44'h00000001000;
    b_valid = 1'b1; b_op = 1'b0; b_data = 44'h00000002000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("alt_ready", 64'({a_ready, b_ready}), (i % 2 == 0) ? 64'd2 : 64'd1);
      @(posedge clk);
    end
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    drain();

    // Back-pressure hold; B operand changes before its grant.
    rsp_ready = 1'b0;
    issue(0, 0, 44'h00000004000, 44'h00000004204, 0, 0);
    a_valid = 1'b1; a_op = 1'b0; a_data = 44'h00000010000;
    b_valid = 1'b1; b_op = 1'b1; b_data = 44'h12345678ABC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_ready", 64'({a_ready, b_ready}), 64'd0);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_data",  64'(rsp_data),  64'h00000004204);
      if (i == 1) b_data = 44'h00000001881;
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    sb.push_back({1'b1, 44'h00000001000, 1'b0, 1'b1});
    resid_exp++;
    sb.push_back({1'b0, 44'h00000010810, 1'b0, 1'b0});
    @(negedge clk);
    check("resume_rr_b", 64'({a_ready, b_ready}), 64'd1);
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    @(negedge clk);
    check("resume_then_a", 64'({a_ready, b_ready}), 64'd2);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    drain();
    check_cnts();

    // Reset while a result is held.
    rsp_ready = 1'b0;
    issue(0, 1, 44'h00000000081, 44'h00000001000, 1, 0);
    a_valid = 1'b1; a_op = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 64'(rsp_valid), 64'd1);
    check("pre_rst_corr",  64'(corr_cnt),  64'(corr_exp));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_data",  64'(rsp_data),  64'd0);
    check("mid_rst_cnt",   64'(corr_cnt),  64'd0);
    check("mid_rst_ready", 64'(a_ready),   64'd0);
    sb.delete();
    corr_exp = 0;
    a_valid  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(rsp_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
